// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One trial subtraction per clock (adder with inverted divisor, carry-in 1),
// WIDTH iterations per division; divide-by-zero short-circuits to DONE.
module seq_divider #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] d_reg, q_reg, r_reg;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] r_shift;
   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] r_next, q_next;
   logic             last_iter;

   // One restoring step: shift in next dividend bit, trial-subtract the divisor
   always_comb begin
      r_shift   = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      // {0,R'} - {0,D} as an add of the inverted divisor with carry-in 1;
      // the extra top bit is the borrow, so all-ones operands cannot overflow
      trial     = {1'b0, r_shift} + {1'b1, ~d_reg} + {{WIDTH{1'b0}}, 1'b1};
      fits      = ~trial[WIDTH];
      r_next    = fits ? trial[WIDTH-1:0] : r_shift;
      q_next    = {q_reg[WIDTH-2:0], fits};
      last_iter = (cnt == CNT_W'(WIDTH - 1));
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d_reg       <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  d_reg       <= divisor;
                  q_reg       <= dividend;
                  r_reg       <= '0;
                  cnt         <= '0;
                  div_by_zero <= (divisor == '0);
                  // zero divisor skips RUN, so its results are written here
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                  end
               end
            end
            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               cnt   <= cnt + CNT_W'(1);
               if (last_iter) begin
                  quotient  <= q_next;
                  remainder <= r_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider at WIDTH=8 and 64.
module tb_seq_divider;

   localparam logic [63:0] ONES = '1;

   logic        clk;
   logic        reset_n;

   logic        st8, busy8, done8, dbz8;
   logic [7:0]  a8, b8, q8, r8;
   logic        st64, busy64, done64, dbz64;
   logic [63:0] a64, b64, q64, r64;

   int total;
   int bad;

   seq_divider #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .start(st8), .dividend(a8), .divisor(b8),
      .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
   );

   seq_divider #(.WIDTH(64)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .start(st64), .dividend(a64), .divisor(b64),
      .busy(busy64), .done(done64), .quotient(q64), .remainder(r64), .div_by_zero(dbz64)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input bit wide, input logic s, input logic [63:0] a, input logic [63:0] b);
      if (wide) begin
         st64 = s; a64 = a; b64 = b;
      end else begin
         st8 = s; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   function automatic logic get_done(input bit wide);
      return wide ? done64 : done8;
   endfunction

   function automatic logic get_busy(input bit wide);
      return wide ? busy64 : busy8;
   endfunction

   function automatic logic [63:0] get_q(input bit wide);
      return wide ? q64 : {56'd0, q8};
   endfunction

   function automatic logic [63:0] get_r(input bit wide);
      return wide ? r64 : {56'd0, r8};
   endfunction

   function automatic logic get_dbz(input bit wide);
      return wide ? dbz64 : dbz8;
   endfunction

   // Issue one operation; lat counts edges from the accept edge (accept = 1)
   // to the first sample with done high; operands are scrambled after accept.
   task automatic do_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                        input bit pulse_mid, output int lat, output int bcnt);
      @(posedge clk); #1;
      set_in(wide, 1'b1, a, b);
      @(posedge clk); #1;
      set_in(wide, 1'b0, ~a, b + 64'd3);
      lat  = 1;
      bcnt = 0;
      while (!get_done(wide) && lat < 300) begin
         if (get_busy(wide)) bcnt++;
         if (pulse_mid && lat == 4) set_in(wide, 1'b1, 64'd50, 64'd3);
         else set_in(wide, 1'b0, ~a, b + 64'd3);
         @(posedge clk); #1;
         lat++;
      end
      set_in(wide, 1'b0, ~a, b + 64'd3);
   endtask

   task automatic check_zero8(input string tag);
      check({tag, "_busy"}, {63'd0, busy8}, 64'd0);
      check({tag, "_done"}, {63'd0, done8}, 64'd0);
      check({tag, "_q"}, {56'd0, q8}, 64'd0);
      check({tag, "_r"}, {56'd0, r8}, 64'd0);
      check({tag, "_dbz"}, {63'd0, dbz8}, 64'd0);
   endtask

   initial begin
      int lat, bcnt, n;
      bit seen;
      logic [63:0] a, b, eq, er, prod;

      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      set_in(1'b0, 1'b0, 64'd0, 64'd0);
      set_in(1'b1, 1'b0, 64'd0, 64'd0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero8("rst8");
      check("rst64_q", q64, 64'd0);
      check("rst64_busy", {63'd0, busy64}, 64'd0);
      reset_n = 1'b1;

      // basic 100/7
      do_op(1'b0, 64'd100, 64'd7, 1'b0, lat, bcnt);
      check("basic_lat", 64'(lat), 64'd9);
      check("basic_q", get_q(0), 64'd14);
      check("basic_r", get_r(0), 64'd2);
      check("basic_dbz", {63'd0, dbz8}, 64'd0);
      check("basic_busycnt", 64'(bcnt), 64'd8);
      @(posedge clk); #1;
      check("basic_pulse", {63'd0, done8}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("basic_hold_q", get_q(0), 64'd14);
      check("basic_hold_r", get_r(0), 64'd2);

      // divide by zero
      do_op(1'b0, 64'd200, 64'd0, 1'b0, lat, bcnt);
      check("dz_lat", 64'(lat), 64'd1);
      check("dz_q", get_q(0), 64'hFF);
      check("dz_r", get_r(0), 64'd200);
      check("dz_dbz", {63'd0, dbz8}, 64'd1);
      check("dz_busycnt", 64'(bcnt), 64'd0);

      // asynchronous reset mid-run
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 64'd100, 64'd7);
      @(posedge clk); #1;
      set_in(1'b0, 1'b0, 64'd0, 64'd0);
      repeat (3) @(posedge clk);
      #3;
      check("midrst_busy_before", {63'd0, busy8}, 64'd1);
      reset_n = 1'b0;
      #1;
      check_zero8("midrst");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done8) seen = 1'b1;
      end
      check("midrst_nodone", {63'd0, seen}, 64'd0);
      do_op(1'b0, 64'd100, 64'd7, 1'b0, lat, bcnt);
      check("postrst_q", get_q(0), 64'd14);
      check("postrst_r", get_r(0), 64'd2);

      // 8-bit equal operands
      do_op(1'b0, 64'd173, 64'd173, 1'b0, lat, bcnt);
      check("eq8_q", get_q(0), 64'd1);
      check("eq8_r", get_r(0), 64'd0);

      // start pulsed mid-run is ignored
      do_op(1'b0, 64'd100, 64'd7, 1'b1, lat, bcnt);
      check("ign_lat", 64'(lat), 64'd9);
      check("ign_q", get_q(0), 64'd14);
      check("ign_r", get_r(0), 64'd2);

      // start held high across DONE
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 64'd20, 64'd3);
      @(posedge clk); #1;
      set_in(1'b0, 1'b1, 64'd45, 64'd6);
      n = 1;
      while (!done8 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold1_lat", 64'(n), 64'd9);
      check("hold1_q", get_q(0), 64'd6);
      check("hold1_r", get_r(0), 64'd2);
      @(posedge clk); #1;
      check("hold_idle_busy", {63'd0, busy8}, 64'd0);
      @(posedge clk); #1;
      check("hold_reaccept", {63'd0, busy8}, 64'd1);
      set_in(1'b0, 1'b0, 64'd0, 64'd0);
      n = 11;
      while (!done8 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold2_lat", 64'(n), 64'd19);
      check("hold2_q", get_q(0), 64'd7);
      check("hold2_r", get_r(0), 64'd3);

      // 64-bit boundaries
      do_op(1'b1, 64'd5, 64'd9, 1'b0, lat, bcnt);
      check("b64_lt_lat", 64'(lat), 64'd65);
      check("b64_lt_q", q64, 64'd0);
      check("b64_lt_r", r64, 64'd5);
      do_op(1'b1, ONES, 64'd1, 1'b0, lat, bcnt);
      check("b64_d1_lat", 64'(lat), 64'd65);
      check("b64_d1_q", q64, ONES);
      check("b64_d1_r", r64, 64'd0);
      do_op(1'b1, ONES, ONES, 1'b0, lat, bcnt);
      check("b64_eq_lat", 64'(lat), 64'd65);
      check("b64_eq_q", q64, 64'd1);
      check("b64_eq_r", r64, 64'd0);
      check("b64_eq_busycnt", 64'(bcnt), 64'd64);

      // random 64-bit pairs against a reference model
      for (int i = 0; i < 1000; i++) begin
         a = {$urandom(), $urandom()};
         case (i % 10)
            0: b = 64'd0;
            1: b = 64'($urandom_range(1, 255));
            2: b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            3: begin b = {$urandom(), $urandom()}; a = a >> $urandom_range(0, 63); end
            default: b = {$urandom(), $urandom()};
         endcase
         if (b == 64'd0) begin
            eq = ONES;
            er = a;
         end else begin
            eq = a / b;
            er = a % b;
         end
         do_op(1'b1, a, b, 1'b0, lat, bcnt);
         check("rnd_lat", 64'(lat), (b == 64'd0) ? 64'd1 : 64'd65);
         check("rnd_q", q64, eq);
         check("rnd_r", r64, er);
         check("rnd_dbz", {63'd0, dbz64}, (b == 64'd0) ? 64'd1 : 64'd0);
         if (b != 64'd0) begin
            prod = q64 * b + r64;
            check("rnd_inv", {63'd0, (prod == a) && (r64 < b)}, 64'd1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
